// File: rtl/tree_loader_if.sv
// tree_loader_if: node stream and treeval sideband bundle for tree_loader.
//   master (loader side): takes in_valid/in_node, drives in_ready and all
//                         mem_*/conf_* write signals.
//   slave  (host + treeval side): drives in_valid/in_node, observes the rest.
//   in_valid/in_ready/in_node       packed-node stream, transfer = valid & ready
//   mem_par/act/rew/weight          one-hot field write strobes
//   mem_addr, mem_data              target node address and field payload
//   conf_nodes, conf_data           node-count config write
interface tree_loader_if #(
    parameter int unsigned NODE_SIZE = 32,
    parameter int unsigned W_ADDR    = 10,
    parameter int unsigned W_DATA    = 10
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [NODE_SIZE-1:0] in_node;
    logic                 mem_par;
    logic                 mem_act;
    logic                 mem_rew;
    logic                 mem_weight;
    logic [W_ADDR-1:0]    mem_addr;
    logic [W_DATA-1:0]    mem_data;
    logic                 conf_nodes;
    logic [W_DATA-1:0]    conf_data;

    modport master (
        input  in_valid, in_node,
        output in_ready, mem_par, mem_act, mem_rew, mem_weight,
               mem_addr, mem_data, conf_nodes, conf_data
    );

    modport slave (
        output in_valid, in_node,
        input  in_ready, mem_par, mem_act, mem_rew, mem_weight,
               mem_addr, mem_data, conf_nodes, conf_data
    );
endinterface

// File: rtl/tree_loader.sv
// tree_loader: writer side of the treeval node/config sideband. Accepts packed
// 32-bit nodes in address order 0..N-1 and unpacks each into four one-cycle
// field writes (parent, action+strat, reward, weight), preceded by a single
// node-count config write. All outputs are registered.
//   clk, rst   clock, synchronous active-high reset
//   start      begin a load (IDLE only); cfg_nodes (2..1023) latched with it
//   bus        tree_loader_if.master: node stream in, sideband writes out
//   busy       load in progress
//   done       one-cycle pulse after the last field write of a load
//   err        sticky parent-order error, cleared by rst or an accepted start
// Optional feature macro: TREE_LOADER_PARENT_CHECK_EN. When defined, a node at
// addr>0 whose parent is >= its own address aborts the load: no parent write,
// err is set and the load ends through FIN. When undefined err is tied low.
module tree_loader #(
    localparam int unsigned NODE_SIZE = 32,
    localparam int unsigned W_ADDR    = 10,
    localparam int unsigned W_DATA    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_ADDR-1:0] cfg_nodes,
    tree_loader_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              err
);
    // Packed node field positions
    localparam int unsigned PAR_LSB   = 22;
    localparam int unsigned ACT_LSB   = 19;
    localparam int unsigned ACT_W     = 3;
    localparam int unsigned STRAT_BIT = 18;
    localparam int unsigned REW_LSB   = 8;
    localparam int unsigned WGT_W     = 8;
    localparam logic [W_DATA-1:0] ROOT_PARENT = W_DATA'(10'h3FF);

    typedef enum logic [2:0] {
        IDLE, CONF, WAIT, PAR, ACT, REW, WGT, FIN
    } state_t;

    state_t                state_q, state_n;
    logic [W_ADDR-1:0]     addr_q, addr_n;
    logic [W_ADDR-1:0]     nodes_q, nodes_n;
    logic [NODE_SIZE-1:0]  node_q, node_n;
    logic                  xfer;
    logic                  bad_cur, bad_nxt;

    logic                  in_ready_n;
    logic                  par_n, act_n, rew_n, wgt_n, conf_n;
    logic [W_ADDR-1:0]     mem_addr_n;
    logic [W_DATA-1:0]     mem_data_n;
    logic [W_DATA-1:0]     conf_data_n;

    assign xfer = bus.in_valid & bus.in_ready;

    // Parent-order check on the node being written (cur) and the node about to
    // enter PAR (nxt); the latter suppresses the parent strobe before it is issued.
`ifdef TREE_LOADER_PARENT_CHECK_EN
    logic err_q, err_n;

    assign bad_cur = (addr_q != '0) && (node_q[PAR_LSB +: W_ADDR] >= addr_q);
    assign bad_nxt = (addr_n != '0) && (node_n[PAR_LSB +: W_ADDR] >= addr_n);
    assign err     = err_q;
`else
    assign bad_cur = 1'b0;
    assign bad_nxt = 1'b0;
    assign err     = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        nodes_n = nodes_q;
        node_n  = node_q;
`ifdef TREE_LOADER_PARENT_CHECK_EN
        err_n   = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start && (cfg_nodes >= W_ADDR'(2))) begin
                    nodes_n = cfg_nodes;
                    addr_n  = '0;
`ifdef TREE_LOADER_PARENT_CHECK_EN
                    err_n   = 1'b0;
`endif
                    state_n = CONF;
                end
            end
            CONF: state_n = WAIT;
            WAIT: begin
                if (xfer) begin
                    node_n  = bus.in_node;
                    state_n = PAR;
                end
            end
            PAR: begin
                if (bad_cur) begin
`ifdef TREE_LOADER_PARENT_CHECK_EN
                    err_n   = 1'b1;
`endif
                    state_n = FIN;
                end else begin
                    state_n = ACT;
                end
            end
            ACT: state_n = REW;
            REW: state_n = WGT;
            WGT: begin
                if (addr_q == (nodes_q - W_ADDR'(1))) begin
                    state_n = FIN;
                end else begin
                    addr_n = addr_q + W_ADDR'(1);
                    if (xfer) begin
                        node_n  = bus.in_node;
                        state_n = PAR;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it
        in_ready_n  = (state_n == WAIT) ||
                      ((state_n == WGT) && (addr_n != (nodes_n - W_ADDR'(1))));
        par_n       = (state_n == PAR) && !bad_nxt;
        act_n       = (state_n == ACT);
        rew_n       = (state_n == REW);
        wgt_n       = (state_n == WGT);
        conf_n      = (state_n == CONF);

        mem_addr_n  = bus.mem_addr;
        mem_data_n  = bus.mem_data;
        conf_data_n = bus.conf_data;

        // Address/data move only together with a field strobe
        if (par_n || act_n || rew_n || wgt_n) begin
            mem_addr_n = addr_n;
        end
        if (par_n) begin
            mem_data_n = (addr_n == '0) ? ROOT_PARENT
                                        : W_DATA'(node_n[PAR_LSB +: W_ADDR]);
        end else if (act_n) begin
            mem_data_n = W_DATA'({node_n[STRAT_BIT], node_n[ACT_LSB +: ACT_W]});
        end else if (rew_n) begin
            mem_data_n = W_DATA'(node_n[REW_LSB +: W_DATA]);
        end else if (wgt_n) begin
            mem_data_n = (addr_n == '0) ? '0 : W_DATA'(node_n[WGT_W-1:0]);
        end
        if (conf_n) begin
            conf_data_n = W_DATA'(nodes_n);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            nodes_q        <= '0;
            node_q         <= '0;
            bus.in_ready   <= 1'b0;
            bus.mem_par    <= 1'b0;
            bus.mem_act    <= 1'b0;
            bus.mem_rew    <= 1'b0;
            bus.mem_weight <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_data   <= '0;
            bus.conf_nodes <= 1'b0;
            bus.conf_data  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_n;
            addr_q         <= addr_n;
            nodes_q        <= nodes_n;
            node_q         <= node_n;
            bus.in_ready   <= in_ready_n;
            bus.mem_par    <= par_n;
            bus.mem_act    <= act_n;
            bus.mem_rew    <= rew_n;
            bus.mem_weight <= wgt_n;
            bus.mem_addr   <= mem_addr_n;
            bus.mem_data   <= mem_data_n;
            bus.conf_nodes <= conf_n;
            bus.conf_data  <= conf_data_n;
            busy           <= (state_n != IDLE);
            done           <= (state_n == FIN);
        end
    end

`ifdef TREE_LOADER_PARENT_CHECK_EN
    // Sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_n;
        end
    end
`endif

endmodule

// File: tb/tb_tree_loader.sv
// tb_tree_loader: randomized self-checking bench for tree_loader. A reference
// model turns every accepted start and every node transfer into a queue of
// timed write events (config, four field writes, done) and every sampled
// cycle is compared against it, together with in_ready/busy/err expectations.
`timescale 1ns/1ps
module tb_tree_loader;
    localparam int K_CONF = 0;
    localparam int K_PAR  = 1;
    localparam int K_ACT  = 2;
    localparam int K_REW  = 3;
    localparam int K_WGT  = 4;
    localparam int K_DONE = 5;

    typedef struct {
        int kind;
        int addr;
        int data;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] cfg_nodes;
    logic       busy;
    logic       done;
    logic       err;

    tree_loader_if bus ();

    tree_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_nodes (cfg_nodes),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    ev_t         q[$];
    bit          model_busy   = 0;
    bit          release_busy = 0;
    bit          aborted      = 0;
    bit          err_pend     = 0;
    int          err_at       = 0;
    int          model_n      = 0;
    int          sent         = 0;
    int          exp_addr     = 0;
    int          exp_data     = 0;
    int          exp_conf     = 0;
    bit          xfer_flag    = 0;
    int          last_xfer    = 0;
    logic [31:0] nodes [1024];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: node k transferred in cycle t is written at t+1..t+4
    task automatic push_node(input int k, input logic [31:0] nd, input int t);
        ev_t e;
        bit  bad;
        int  parent;
        parent = int'(nd[31:22]);
        bad = 0;
`ifdef TREE_LOADER_PARENT_CHECK_EN
        bad = (k > 0) && (parent >= k);
`endif
        if (bad) begin
            aborted  = 1;
            err_pend = 1;
            err_at   = t + 2;
            e = '{K_DONE, 0, 0, t + 2};
            q.push_back(e);
        end else begin
            e = '{K_PAR, k, (k == 0) ? 'h3FF : parent, t + 1};
            q.push_back(e);
            e = '{K_ACT, k, int'(nd[18]) * 8 + int'(nd[21:19]), t + 2};
            q.push_back(e);
            e = '{K_REW, k, int'(nd[17:8]), t + 3};
            q.push_back(e);
            e = '{K_WGT, k, (k == 0) ? 0 : int'(nd[7:0]), t + 4};
            q.push_back(e);
            if (k == model_n - 1) begin
                e = '{K_DONE, 0, 0, t + 5};
                q.push_back(e);
            end
        end
    endtask

    // One clock: update model from pre-edge inputs, then sample and compare
    task automatic step();
        bit  acc;
        bit  xf;
        bit  do_rst;
        bit  rdy_exp;
        int  obs;
        int  kind;
        ev_t e;
        do_rst = rst;
        xf  = !rst && bus.in_valid && bus.in_ready;
        acc = !rst && start && !model_busy && (int'(cfg_nodes) >= 2);
        if (acc) begin
            model_busy = 1;
            model_n    = int'(cfg_nodes);
            sent       = 0;
            aborted    = 0;
            err_pend   = 0;
            e = '{K_CONF, 0, int'(cfg_nodes), cyc + 1};
            q.push_back(e);
        end
        if (xf) begin
            if (!model_busy || aborted || sent >= model_n) begin
                check("xfer_allowed", 1, 0);
            end else begin
                push_node(sent, bus.in_node, cyc);
                sent++;
            end
            xfer_flag = 1;
            last_xfer = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (do_rst) begin
            q.delete();
            model_busy   = 0;
            release_busy = 0;
            aborted      = 0;
            err_pend     = 0;
            exp_addr     = 0;
            exp_data     = 0;
            exp_conf     = 0;
            sent         = 0;
            model_n      = 0;
        end
        if (release_busy) begin
            model_busy   = 0;
            release_busy = 0;
        end
        obs  = int'(bus.mem_par) + int'(bus.mem_act) + int'(bus.mem_rew) +
               int'(bus.mem_weight) + int'(bus.conf_nodes) + int'(done);
        kind = -1;
        if (bus.conf_nodes) kind = K_CONF;
        if (bus.mem_par)    kind = K_PAR;
        if (bus.mem_act)    kind = K_ACT;
        if (bus.mem_rew)    kind = K_REW;
        if (bus.mem_weight) kind = K_WGT;
        if (done)           kind = K_DONE;
        if (obs > 1) check("strobe_onehot", obs, 1);
        while (q.size() > 0 && q[0].cyc < cyc) begin
            check("missing_event", -1, q[0].kind);
            e = q.pop_front();
            if (e.kind == K_DONE) release_busy = 1;
        end
        if (kind >= 0) begin
            if (q.size() == 0) begin
                check("unexpected_event", kind, -1);
            end else begin
                e = q.pop_front();
                check("event_kind", kind, e.kind);
                check("event_cycle", cyc, e.cyc);
                if (e.kind == K_CONF) begin
                    exp_conf = e.data;
                end else if (e.kind == K_DONE) begin
                    release_busy = 1;
                end else begin
                    exp_addr = e.addr;
                    exp_data = e.data;
                end
            end
        end
        check("mem_addr", int'(bus.mem_addr), exp_addr);
        check("mem_data", int'(bus.mem_data), exp_data);
        check("conf_data", int'(bus.conf_data), exp_conf);
        rdy_exp = model_busy && !aborted && (q.size() == 0) && (sent < model_n) &&
                  (kind != K_CONF);
        check("in_ready", int'(bus.in_ready), int'(rdy_exp));
        check("busy", int'(busy), int'(model_busy));
        check("err", int'(err), int'(err_pend && (cyc >= err_at)));
    endtask

    function automatic logic [31:0] make_node(input int k);
        logic [31:0] v;
        v = $urandom;
        v[7:0] = 8'($urandom_range(128, 0));
`ifdef TREE_LOADER_PARENT_CHECK_EN
        if (k > 0) v[31:22] = 10'($urandom_range(k - 1, 0));
`else
        if (k < 0) v = '0;
`endif
        return v;
    endfunction

    // mode 0: back-to-back valid; 1: random valid + stray starts; 2: one long gap
    task automatic run_load(input int n, input int mode, input int gap_after, input bit fresh);
        int budget;
        int prev;
        int gap;
        bit v;
        if (fresh) begin
            for (int k = 0; k < n; k++) nodes[k] = make_node(k);
        end
        start = 1;
        cfg_nodes = 10'(n);
        bus.in_valid = 0;
        step();
        start  = 0;
        budget = n * 8 + 60;
        prev   = -1;
        gap    = 0;
        while (model_busy && budget > 0) begin
            if (sent < n) begin
                if (mode == 1) v = ($urandom_range(2, 0) != 0);
                else           v = 1;
                if (gap > 0) begin
                    v = 0;
                    gap--;
                end
            end else begin
                v = $urandom_range(1, 0) != 0;
            end
            bus.in_valid = v;
            bus.in_node  = (v && sent < n) ? nodes[sent] : $urandom;
            start        = (mode == 1) && ($urandom_range(7, 0) == 0);
            cfg_nodes    = 10'($urandom);
            xfer_flag    = 0;
            step();
            budget--;
            if (xfer_flag) begin
                if (mode == 0 && prev >= 0) check("b2b_spacing", last_xfer - prev, 4);
                prev = last_xfer;
                if (mode == 2 && sent == gap_after) gap = 9;
            end
        end
        start = 0;
        bus.in_valid = 0;
        check("load_finished", int'(model_busy), 0);
        if (!aborted) check("nodes_sent", sent, n);
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1;
        start        = 0;
        cfg_nodes    = '0;
        bus.in_valid = 0;
        bus.in_node  = '0;
        step();
        step();
        check("rst_done", int'(done), 0);
        check("rst_conf_nodes", int'(bus.conf_nodes), 0);
        rst = 0;
        step();

        // Directed: 3-node load with known root and node 1 contents
        nodes[0] = make_node(0);
        nodes[0][31:22] = 10'h155;
        nodes[0][7:0]   = 8'h40;
        nodes[1] = {10'h000, 3'd2, 1'b1, 10'h3FB, 8'h80};
        nodes[2] = make_node(2);
        run_load(3, 0, 0, 0);

        // Stall mid-load with in_valid low
        run_load(6, 2, 3, 1);

        // Reset while node 1 reward is being written
        for (int k = 0; k < 5; k++) nodes[k] = make_node(k);
        start = 1;
        cfg_nodes = 10'd5;
        step();
        start = 0;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = (sent < 5);
            bus.in_node  = nodes[sent < 5 ? sent : 0];
            step();
            if (bus.mem_rew && bus.mem_addr == 10'd1) break;
        end
        check("rew1_reached", int'(bus.mem_rew && bus.mem_addr == 10'd1), 1);
        rst = 1;
        bus.in_valid = 0;
        step();
        check("rst_mid_busy", int'(busy), 0);
        rst = 0;
        step();
        run_load(4, 0, 0, 1);

        // Starts with too few nodes are ignored
        start = 1;
        cfg_nodes = 10'd1;
        step();
        cfg_nodes = 10'd0;
        step();
        start = 0;
        for (int i = 0; i < 4; i++) step();
        check("small_start_ignored", int'(busy), 0);

        // Random loads, then a maximum-size back-to-back load
        for (int r = 0; r < 8; r++) run_load(int'($urandom_range(20, 2)), 1, 0, 1);
        run_load(2, 0, 0, 1);
        run_load(1023, 0, 0, 1);

`ifdef TREE_LOADER_PARENT_CHECK_EN
        // Parent-order violation at node 2 aborts the load
        for (int k = 0; k < 4; k++) nodes[k] = make_node(k);
        nodes[2][31:22] = 10'd2;
        run_load(4, 0, 0, 0);
        check("err_sticky", int'(err), 1);
        run_load(3, 1, 0, 1);
        check("err_cleared", int'(err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
